// File: rtl/imm_sequencer.sv
// Constant-materialization sequencer: turns a 64-bit constant into a MOVZ/MOVK (optionally MOVN) IW stream.
// Optional feature: define IMMSEQ_MOVN_EN to start with MOVN when most halfwords are 16'hFFFF.
module imm_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] Value,
  input  logic [4:0]  Rd,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Instr,
  output logic        Last
);
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;
`ifdef IMMSEQ_MOVN_EN
  localparam logic [8:0] OP_MOVN = 9'b100100101;
`endif

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nx;

  logic [63:0] val_q, val_nx;
  logic [4:0]  rd_q, rd_nx;
  logic [3:0]  mask_q, mask_nx;  // halfwords still to be emitted as MOVK
  logic [31:0] instr_nx;
  logic        last_nx, ovld_nx;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else if (m[2]) lowest = 2'd2;
    else if (m[3]) lowest = 2'd3;
    else           lowest = 2'd0;
  endfunction

  function automatic logic [31:0] enc(input logic [8:0] op, input logic [1:0] hw,
                                      input logic [15:0] imm, input logic [4:0] rd);
    enc = {op, hw, imm, rd};
  endfunction

  // First-word selection from the incoming Value
  logic [3:0]  acc_mask;
  logic [1:0]  acc_hw;
  logic [15:0] acc_imm;
  logic [8:0]  acc_op;
  always_comb begin
    acc_mask = 4'b0;
    for (int k = 0; k < 4; k++) acc_mask[k] = (Value[16*k +: 16] != 16'h0);
    acc_op = OP_MOVZ;
`ifdef IMMSEQ_MOVN_EN
    begin
      logic [2:0] ones, zeros;
      logic [3:0] notff;
      ones  = 3'd0;
      zeros = 3'd0;
      notff = 4'b0;
      for (int k = 0; k < 4; k++) begin
        notff[k] = (Value[16*k +: 16] != 16'hFFFF);
        if (!notff[k]) ones = ones + 3'd1;
        if (!acc_mask[k]) zeros = zeros + 3'd1;
      end
      if (ones > zeros) begin
        acc_mask = notff;
        acc_op   = OP_MOVN;
      end
    end
`endif
    acc_hw  = lowest(acc_mask);
    acc_imm = Value[{acc_hw, 4'b0} +: 16];
`ifdef IMMSEQ_MOVN_EN
    if (acc_op == OP_MOVN) acc_imm = ~acc_imm;
`endif
  end

  logic [1:0] nxt_hw;
  always_comb begin
    state_nx = state;
    val_nx   = val_q;
    rd_nx    = rd_q;
    mask_nx  = mask_q;
    instr_nx = Instr;
    last_nx  = Last;
    ovld_nx  = OutValid;
    nxt_hw   = lowest(mask_q);
    case (state)
      IDLE: if (InValid) begin
        state_nx = EMIT;
        val_nx   = Value;
        rd_nx    = Rd;
        mask_nx  = acc_mask & ~(4'b1 << acc_hw);
        instr_nx = enc(acc_op, acc_hw, acc_imm, Rd);
        last_nx  = ((acc_mask & ~(4'b1 << acc_hw)) == 4'b0);
        ovld_nx  = 1'b1;
      end
      EMIT: if (OutReady) begin
        if (Last) begin
          state_nx = IDLE;
          mask_nx  = 4'b0;
          instr_nx = 32'h0;
          last_nx  = 1'b0;
          ovld_nx  = 1'b0;
        end else begin
          mask_nx  = mask_q & ~(4'b1 << nxt_hw);
          instr_nx = enc(OP_MOVK, nxt_hw, val_q[{nxt_hw, 4'b0} +: 16], rd_q);
          last_nx  = ((mask_q & ~(4'b1 << nxt_hw)) == 4'b0);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      val_q    <= 64'h0;
      rd_q     <= 5'h0;
      mask_q   <= 4'h0;
      Instr    <= 32'h0;
      Last     <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      state    <= state_nx;
      val_q    <= val_nx;
      rd_q     <= rd_nx;
      mask_q   <= mask_nx;
      Instr    <= instr_nx;
      Last     <= last_nx;
      OutValid <= ovld_nx;
    end
  end

  assign InReady = (state == IDLE) && !Reset;
endmodule

// File: tb/tb_imm_sequencer.sv
// Directed bench for imm_sequencer: hand-computed IW encodings checked with immediate assertions.
module tb_imm_sequencer;
  logic        CLK = 1'b0;
  logic        Reset, InValid, InReady, OutValid, OutReady, Last;
  logic [63:0] Value;
  logic [4:0]  Rd;
  logic [31:0] Instr;
  int n_chk = 0;
  int n_fail = 0;

  imm_sequencer dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Value(Value), .Rd(Rd), .OutValid(OutValid), .OutReady(OutReady),
    .Instr(Instr), .Last(Last)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Present a request for one edge; afterwards the first word is on the outputs
  task automatic req(input logic [63:0] v, input logic [4:0] r);
    chk("req_inready", {31'b0, InReady}, 32'd1);
    InValid = 1'b1; Value = v; Rd = r;
    tick();
    InValid = 1'b0;
  endtask

  // Check the presented word with OutReady=1, then take it
  task automatic word(input string tag, input logic [31:0] exp, input logic exp_last);
    OutReady = 1'b1;
    chk({tag, "_vld"},   {31'b0, OutValid}, 32'd1);
    chk({tag, "_instr"}, Instr, exp);
    chk({tag, "_last"},  {31'b0, Last}, {31'b0, exp_last});
    chk({tag, "_inrdy"}, {31'b0, InReady}, 32'd0);
    tick();
  endtask

  task automatic idle(input string tag);
    chk({tag, "_idle_vld"}, {31'b0, OutValid}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'b0, InReady}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Value = 64'h0; Rd = 5'h0;
    tick(); tick();
    chk("rst_vld",   {31'b0, OutValid}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_last",  {31'b0, Last}, 32'd0);
    chk("rst_inrdy", {31'b0, InReady}, 32'd0);
    Reset = 1'b0; #1;
    idle("post_rst");

    // zero constant: single MOVZ
    OutReady = 1'b1;
    req(64'h0, 5'd3);
    word("zero", 32'hD2800003, 1'b1);
    idle("zero");

    // two nonzero halfwords, no backpressure
    req(64'h0000_1234_0000_5678, 5'd1);
    word("two_w0", 32'hD28ACF01, 1'b0);
    word("two_w1", 32'hF2C24681, 1'b1);
    idle("two");

    // same request with 3 cycles of backpressure on the first word
    OutReady = 1'b0;
    req(64'h0000_1234_0000_5678, 5'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_vld",   {31'b0, OutValid}, 32'd1);
      chk("bp_instr", Instr, 32'hD28ACF01);
      chk("bp_last",  {31'b0, Last}, 32'd0);
      chk("bp_inrdy", {31'b0, InReady}, 32'd0);
      tick();
    end
    word("bp_w0", 32'hD28ACF01, 1'b0);
    word("bp_w1", 32'hF2C24681, 1'b1);
    idle("bp");

    // mostly-ones constant
    req(64'hFFFF_FFFF_FFFF_1234, 5'd2);
`ifdef IMMSEQ_MOVN_EN
    word("ones_movn", 32'h929DB962, 1'b1);
`else
    word("ones_w0", 32'hD2824682, 1'b0);
    word("ones_w1", 32'hF2BFFFE2, 1'b0);
    word("ones_w2", 32'hF2DFFFE2, 1'b0);
    word("ones_w3", 32'hF2FFFFE2, 1'b1);
`endif
    idle("ones");

    // reset after the second handshake aborts the sequence
    req(64'h1111_2222_3333_4444, 5'd5);
    word("abort_w0", 32'hD2888885, 1'b0);
    word("abort_w1", 32'hF2A66665, 1'b0);
    chk("abort_w2_pending", Instr, 32'hF2C44445);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; #1;
    idle("abort");
    chk("abort_instr", Instr, 32'h0);
    chk("abort_last",  {31'b0, Last}, 32'd0);
    req(64'h0, 5'd7);
    word("after_abort", 32'hD2800007, 1'b1);
    idle("after_abort");

    // InValid held high with Value changing during EMIT
    OutReady = 1'b1;
    InValid = 1'b1; Value = 64'h0005_0000_0000_0007; Rd = 5'd4;
    tick();
    Value = 64'hDEAD_BEEF_CAFE_F00D;
    chk("hold_inrdy", {31'b0, InReady}, 32'd0);
    chk("hold_w0",    Instr, 32'hD28000E4);
    chk("hold_w0l",   {31'b0, Last}, 32'd0);
    OutReady = 1'b0;
    tick();
    Value = 64'h0000_0000_0000_0009;
    chk("hold_w0_bp", Instr, 32'hD28000E4);
    OutReady = 1'b1;
    tick();
    chk("hold_w1",    Instr, 32'hF2E000A4);
    chk("hold_w1l",   {31'b0, Last}, 32'd1);
    tick();
    idle("hold");
    tick();
    InValid = 1'b0;
    word("hold_next", 32'hD2800124, 1'b1);
    idle("hold_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
